// File: rtl/stage_mem_pkg.sv
// Shared widths and FSM encoding for the memory-access pipeline stage.
package stage_mem_pkg;

   localparam int DEF_FULLW = 32;
   localparam int DEF_IDXW  = 4;

   typedef enum logic {
      MEM_IDLE = 1'b0,
      MEM_BUSY = 1'b1
   } mem_state_t;

endpackage

// File: rtl/stage_mem.sv
// Memory stage: passes ALU results through in one cycle, or issues a word
// load/store on the dmem port and stalls EX until ack or timeout.
module stage_mem
   import stage_mem_pkg::*;
#(
   parameter int FULLW   = DEF_FULLW,
   parameter int IDXW    = DEF_IDXW,
   parameter int TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [FULLW-1:0] alu_in,
   input  logic [FULLW-1:0] store_data_in,
   input  logic [IDXW-1:0]  rd_idx_in,
   input  logic             reg_we_in,
   input  logic             mem_we_in,
   input  logic             mem_re_in,
   input  logic             is_invalid_in,
   output logic             dmem_req,
   output logic             dmem_we,
   output logic [FULLW-3:0] dmem_addr,
   output logic [FULLW-1:0] dmem_wdata,
   input  logic [FULLW-1:0] dmem_rdata,
   input  logic             dmem_ack,
   output logic             stall_out,
   output logic [FULLW-1:0] wb_data_out,
   output logic [IDXW-1:0]  wb_idx_out,
   output logic             wb_we_out,
   output logic             is_invalid_out,
   output logic [FULLW-1:0] fwd_data_out,
   output logic [IDXW-1:0]  fwd_idx_out,
   output logic             fwd_valid_out,
   output logic             mem_err_out
);

   localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

   mem_state_t       state, state_nxt;
   logic [15:0]      cnt;
   logic [FULLW-1:0] lat_alu;
   logic [IDXW-1:0]  lat_idx;
   logic             lat_rwe;
   logic             lat_store;
   logic             memop, start, ack_done, tmo;

   // Next state, stall, and the three event strobes that drive the datapath.
   always_comb begin
      memop     = ~is_invalid_in & (mem_we_in | mem_re_in);
      start     = 1'b0;
      ack_done  = 1'b0;
      tmo       = 1'b0;
      stall_out = 1'b0;
      state_nxt = state;
      case (state)
         MEM_IDLE: begin
            stall_out = memop;
            start     = memop;
            if (memop) state_nxt = MEM_BUSY;
         end
         MEM_BUSY: begin
            stall_out = 1'b1;
            if (dmem_ack) begin
               ack_done  = 1'b1;
               state_nxt = MEM_IDLE;
            end else if (cnt == CNT_LAST) begin
               tmo       = 1'b1;
               state_nxt = MEM_IDLE;
            end
         end
         default: state_nxt = MEM_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= MEM_IDLE;
      else     state <= state_nxt;
   end

   // Wait counter: runs only while BUSY is waiting, zero otherwise.
   always_ff @(posedge clk) begin
      if (rst)                                     cnt <= '0;
      else if (state == MEM_BUSY && !ack_done && !tmo) cnt <= cnt + 16'd1;
      else                                         cnt <= '0;
   end

   // Memory request port; fields held steady for the whole access.
   always_ff @(posedge clk) begin
      if (rst) begin
         dmem_req   <= 1'b0;
         dmem_we    <= 1'b0;
         dmem_addr  <= '0;
         dmem_wdata <= '0;
      end else if (start) begin
         dmem_req   <= 1'b1;
         dmem_we    <= mem_we_in;
         dmem_addr  <= alu_in[FULLW-1:2];
         dmem_wdata <= store_data_in;
      end else if (ack_done || tmo) begin
         dmem_req   <= 1'b0;
         dmem_we    <= 1'b0;
      end
   end

   // Capture the instruction at entry; EX is held but never re-sampled.
   always_ff @(posedge clk) begin
      if (rst) begin
         lat_alu   <= '0;
         lat_idx   <= '0;
         lat_rwe   <= 1'b0;
         lat_store <= 1'b0;
      end else if (start) begin
         lat_alu   <= alu_in;
         lat_idx   <= rd_idx_in;
         lat_rwe   <= reg_we_in;
         lat_store <= mem_we_in;   // store wins when both we and re are set
      end
   end

   // Writeback bundle and sticky timeout flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         wb_data_out    <= '0;
         wb_idx_out     <= '0;
         wb_we_out      <= 1'b0;
         is_invalid_out <= 1'b1;
         mem_err_out    <= 1'b0;
      end else if (state == MEM_IDLE) begin
         if (memop) begin
            wb_we_out      <= 1'b0;
            is_invalid_out <= 1'b1;
         end else begin
            wb_data_out    <= alu_in;
            wb_idx_out     <= rd_idx_in;
            wb_we_out      <= reg_we_in & ~is_invalid_in;
            is_invalid_out <= is_invalid_in;
         end
      end else if (ack_done) begin
         wb_data_out    <= lat_store ? lat_alu : dmem_rdata;
         wb_idx_out     <= lat_idx;
         wb_we_out      <= lat_rwe;
         is_invalid_out <= 1'b0;
      end else if (tmo) begin
         wb_we_out      <= 1'b0;
         is_invalid_out <= 1'b1;
         mem_err_out    <= 1'b1;
      end
   end

   assign fwd_data_out  = wb_data_out;
   assign fwd_idx_out   = wb_idx_out;
   assign fwd_valid_out = wb_we_out & ~is_invalid_out;

endmodule

// File: tb/tb_stage_mem.sv
// Randomized bench for stage_mem against a transaction-level memory model.
module tb_stage_mem;

   localparam int FULLW   = 32;
   localparam int IDXW    = 4;
   localparam int TIMEOUT = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic [FULLW-1:0] alu_in, store_data_in, dmem_rdata, dmem_wdata;
   logic [FULLW-1:0] wb_data_out, fwd_data_out;
   logic [IDXW-1:0]  rd_idx_in, wb_idx_out, fwd_idx_out;
   logic             reg_we_in, mem_we_in, mem_re_in, is_invalid_in;
   logic             dmem_req, dmem_we, dmem_ack, stall_out;
   logic [FULLW-3:0] dmem_addr;
   logic             wb_we_out, is_invalid_out, fwd_valid_out, mem_err_out;

   stage_mem #(.FULLW(FULLW), .IDXW(IDXW), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .alu_in(alu_in), .store_data_in(store_data_in),
      .rd_idx_in(rd_idx_in), .reg_we_in(reg_we_in), .mem_we_in(mem_we_in),
      .mem_re_in(mem_re_in), .is_invalid_in(is_invalid_in),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
      .stall_out(stall_out), .wb_data_out(wb_data_out), .wb_idx_out(wb_idx_out),
      .wb_we_out(wb_we_out), .is_invalid_out(is_invalid_out),
      .fwd_data_out(fwd_data_out), .fwd_idx_out(fwd_idx_out),
      .fwd_valid_out(fwd_valid_out), .mem_err_out(mem_err_out)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference state: word-addressed memory and the expected WB bundle.
   logic [FULLW-1:0] mem [int unsigned];
   logic [FULLW-1:0] exp_data;
   logic [IDXW-1:0]  exp_idx;
   logic             exp_we, exp_inv, exp_err, data_known;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_wb(input string tag);
      chk({tag, ".we"},   64'(wb_we_out), 64'(exp_we));
      chk({tag, ".inv"},  64'(is_invalid_out), 64'(exp_inv));
      chk({tag, ".fwdv"}, 64'(fwd_valid_out), 64'(exp_we & ~exp_inv));
      chk({tag, ".err"},  64'(mem_err_out), 64'(exp_err));
      if (data_known) begin
         chk({tag, ".data"},  64'(wb_data_out), 64'(exp_data));
         chk({tag, ".idx"},   64'(wb_idx_out), 64'(exp_idx));
         chk({tag, ".fdata"}, 64'(fwd_data_out), 64'(exp_data));
         chk({tag, ".fidx"},  64'(fwd_idx_out), 64'(exp_idx));
      end
   endtask

   task automatic bubble_in();
      is_invalid_in = 1'b1;
      mem_we_in     = 1'b0;
      mem_re_in     = 1'b0;
      reg_we_in     = 1'b0;
      dmem_ack      = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bubble_in();
      tick();
      rst = 1'b0;
      exp_data = '0; exp_idx = '0; exp_we = 1'b0; exp_inv = 1'b1; exp_err = 1'b0;
      data_known = 1'b1;
      check_wb("reset");
      chk("reset.req", 64'(dmem_req), 64'd0);
      chk("reset.stall", 64'(stall_out), 64'd0);
   endtask

   // Non-memory op (or bubble); optionally a stray ack that must be ignored.
   task automatic do_alu(input logic [FULLW-1:0] a, input logic [IDXW-1:0] idx,
                         input logic rwe, input logic inv, input logic spur);
      alu_in = a; rd_idx_in = idx; reg_we_in = rwe; is_invalid_in = inv;
      mem_we_in = inv ? 1'($urandom) : 1'b0;
      mem_re_in = inv ? 1'($urandom) : 1'b0;
      store_data_in = $urandom;
      dmem_ack = spur; dmem_rdata = $urandom;
      #1 chk("alu.stall", 64'(stall_out), 64'd0);
      tick();
      dmem_ack = 1'b0;
      exp_data = a; exp_idx = idx; exp_we = rwe & ~inv; exp_inv = inv; data_known = 1'b1;
      check_wb("alu");
      chk("alu.req", 64'(dmem_req), 64'd0);
   endtask

   // Memory op; 'delay' busy cycles pass without ack, delay >= TIMEOUT aborts.
   task automatic do_mem(input logic st, input logic ld, input logic [FULLW-1:0] a,
                         input logic [FULLW-1:0] sd, input logic [IDXW-1:0] idx,
                         input logic rwe, input int delay);
      int stalls;
      int waits;
      logic store;
      logic [FULLW-1:0] rd;
      store = st;
      stalls = 0;
      alu_in = a; store_data_in = sd; rd_idx_in = idx; reg_we_in = rwe;
      mem_we_in = st; mem_re_in = ld; is_invalid_in = 1'b0; dmem_ack = 1'b0;
      #1 if (stall_out) stalls++;
      tick();
      chk("mem.req", 64'(dmem_req), 64'd1);
      chk("mem.we", 64'(dmem_we), 64'(store));
      chk("mem.addr", 64'(dmem_addr), 64'(a >> 2));
      chk("mem.wdata", 64'(dmem_wdata), 64'(sd));
      exp_we = 1'b0; exp_inv = 1'b1; data_known = 1'b0;
      check_wb("mem.bub");
      // EX is frozen upstream, but scrambling it proves nothing is re-sampled.
      alu_in = $urandom; store_data_in = $urandom; rd_idx_in = IDXW'($urandom);
      reg_we_in = 1'($urandom); mem_we_in = 1'($urandom);
      waits = (delay < TIMEOUT) ? delay : TIMEOUT;
      for (int c = 0; c < waits; c++) begin
         #1 if (stall_out) stalls++;
         tick();
         if (c < TIMEOUT - 1) chk("mem.hold", 64'(dmem_req), 64'd1);
      end
      if (delay >= TIMEOUT) begin
         exp_err = 1'b1;
         chk("tmo.req", 64'(dmem_req), 64'd0);
         chk("tmo.stalls", 64'(stalls), 64'(1 + TIMEOUT));
         check_wb("tmo");
         bubble_in();
         #1 chk("tmo.stall", 64'(stall_out), 64'd0);
      end else begin
         rd = (!store && mem.exists(a >> 2)) ? mem[a >> 2] : $urandom;
         dmem_rdata = rd; dmem_ack = 1'b1;
         #1 if (stall_out) stalls++;
         tick();
         dmem_ack = 1'b0; dmem_rdata = $urandom;
         if (store) mem[a >> 2] = sd;
         exp_data = store ? a : rd; exp_idx = idx; exp_we = rwe; exp_inv = 1'b0;
         data_known = 1'b1;
         check_wb("ack");
         chk("ack.req", 64'(dmem_req), 64'd0);
         chk("ack.stalls", 64'(stalls), 64'(2 + delay));
         bubble_in();
      end
   endtask

   initial begin
      int op;
      logic [FULLW-1:0] a;
      alu_in = '0; store_data_in = '0; rd_idx_in = '0; dmem_rdata = '0;
      bubble_in();
      do_reset();
      #1 chk("idle.stall", 64'(stall_out), 64'd0);

      // Directed cases.
      do_alu(32'h0000_1234, 4'd5, 1'b1, 1'b0, 1'b0);
      mem[32'h40] = 32'hDEAD_BEEF;
      do_mem(1'b0, 1'b1, 32'h100, 32'h0, 4'd7, 1'b1, 2);
      do_mem(1'b1, 1'b0, 32'h204, 32'hCAFE_F00D, 4'd3, 1'b0, 0);
      do_mem(1'b1, 1'b1, 32'h303, 32'h1111_2222, 4'd9, 1'b1, 1);   // we+re acts as store
      do_mem(1'b0, 1'b1, 32'h300, 32'h0, 4'd2, 1'b1, 0);           // reads it back
      do_mem(1'b0, 1'b1, 32'h80, 32'h0, 4'd1, 1'b1, TIMEOUT);
      do_alu(32'h55, 4'd4, 1'b1, 1'b1, 1'b1);                      // late ack ignored
      do_alu(32'h66, 4'd6, 1'b1, 1'b0, 1'b1);

      // Reset in the second BUSY cycle abandons the access.
      do_mem(1'b0, 1'b1, 32'h40, 32'h0, 4'd8, 1'b1, 99 * 0 + 0) ; // quick load first
      alu_in = 32'h44; rd_idx_in = 4'd2; reg_we_in = 1'b1;
      mem_re_in = 1'b1; mem_we_in = 1'b0; is_invalid_in = 1'b0; dmem_ack = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      bubble_in();
      tick();
      rst = 1'b0;
      chk("rst.req", 64'(dmem_req), 64'd0);
      chk("rst.stall", 64'(stall_out), 64'd0);
      chk("rst.inv", 64'(is_invalid_out), 64'd1);
      chk("rst.err", 64'(mem_err_out), 64'd0);
      exp_data = '0; exp_idx = '0; exp_we = 1'b0; exp_inv = 1'b1; exp_err = 1'b0;
      data_known = 1'b1;
      check_wb("rst");

      // Random mix of ALU ops, bubbles, loads, stores, timeouts and resets.
      for (int n = 0; n < 400; n++) begin
         op = $urandom_range(0, 19);
         a = {26'($urandom_range(0, 15)), 6'($urandom)};
         if (op < 7)
            do_alu($urandom, IDXW'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0),
                   ($urandom_range(0, 4) == 0));
         else if (op < 12)
            do_mem(1'b0, 1'b1, a, $urandom, IDXW'($urandom), 1'($urandom),
                   $urandom_range(0, TIMEOUT + 1));
         else if (op < 18)
            do_mem(1'b1, 1'($urandom), a, $urandom, IDXW'($urandom), 1'($urandom),
                   $urandom_range(0, TIMEOUT));
         else
            do_reset();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Watchdog: the run is bounded; an overrun counts as a failure.
   initial begin
      #500000;
      errors++;
      $display("FAIL watchdog: got timeout expected finish");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1);
   end

endmodule

// File: doc/stage_mem.md
Name: stage_mem

Overview:
- Memory-access pipeline stage directly downstream of the execute stage. Consumes the ALU result, store data, destination index and write-enable controls that EX produces.
- Performs word loads and stores over a request/acknowledge data-memory port. Stalls upstream while an access is outstanding.
- Presents a registered writeback bundle plus a forwarding bus back to EX for the rm bypass mux.

Parameters:
- FULLW, 32, datapath and memory word width.
- IDXW, 4, register index width.
- TIMEOUT, 255, max cycles waiting for dmem_ack before abort (1..2^16-1).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- alu_in  in  FULLW  EX result; byte address for memory ops, else the writeback value
- store_data_in  in  FULLW  store data (EX rd value)
- rd_idx_in  in  IDXW  destination register index
- reg_we_in  in  1  instruction writes a register
- mem_we_in  in  1  store
- mem_re_in  in  1  load
- is_invalid_in  in  1  EX bundle is a bubble/squashed
- dmem_req  out  1  memory request, registered
- dmem_we  out  1  1 = write, registered
- dmem_addr  out  FULLW-2  word address = alu_in[FULLW-1:2], registered
- dmem_wdata  out  FULLW  registered store data
- dmem_rdata  in  FULLW  load data, valid with dmem_ack
- dmem_ack  in  1  single-cycle completion pulse
- stall_out  out  1  hold EX/upstream registers this cycle
- wb_data_out  out  FULLW  registered writeback value
- wb_idx_out  out  IDXW  registered writeback index
- wb_we_out  out  1  registered writeback enable
- is_invalid_out  out  1  registered bubble flag to WB
- fwd_data_out  out  FULLW  equals wb_data_out
- fwd_idx_out  out  IDXW  equals wb_idx_out
- fwd_valid_out  out  1  wb_we_out & ~is_invalid_out
- mem_err_out  out  1  sticky timeout flag; cleared only by rst

Behaviour:
- Reset values: state IDLE, dmem_req/dmem_we 0, dmem_addr/dmem_wdata 0, wb_data/wb_idx 0, wb_we 0, is_invalid_out 1, mem_err_out 0, wait counter 0.
- Let memop = ~is_invalid_in & (mem_we_in | mem_re_in). If mem_we_in and mem_re_in are both set, the stage treats the op as a store.
- stall_out (combinational) = (IDLE & memop) | BUSY.
- IDLE, no memop: 1-cycle pass-through. Next edge: wb_data <= alu_in, wb_idx <= rd_idx_in, wb_we <= reg_we_in & ~is_invalid_in, is_invalid_out <= is_invalid_in.
- IDLE, memop:
  - Next edge: state BUSY; dmem_req 1; dmem_we = mem_we_in; addr and wdata latched.
  - Output bundle becomes a bubble (is_invalid_out 1, wb_we 0).
  - Request fields and load/store kind are latched internally, because EX holds but this stage does not re-sample.
- BUSY, dmem_ack=1:
  - Next edge: state IDLE, dmem_req 0, counter 0.
  - Load: wb_data <= dmem_rdata, wb_we <= latched reg_we.
  - Store: wb_we <= latched reg_we, wb_data <= latched alu value.
  - is_invalid_out 0.
  - stall_out is 1 during the ack cycle. The following IDLE cycle samples the next EX bundle.
  - Memory-op latency: 2 cycles minimum (request cycle + ack cycle) from entry to wb output.
- BUSY, no ack: counter increments.
  - When counter == TIMEOUT-1 without ack, next edge: state IDLE, dmem_req 0, mem_err_out 1, bubble written to WB (is_invalid_out 1, wb_we 0). The instruction is dropped.
- Ack while IDLE (late/spurious): ignored.
- rst in any state, including mid-BUSY: all registers go to reset values at that edge, dmem_req drops, and an in-flight access is abandoned.
- dmem_addr low bits are discarded. Misaligned addresses are not flagged.

Decomposition:
- Shared defines file: FULLW, IDXW widths; MEM FSM state encodings (MEM_IDLE=0, MEM_BUSY=1).
- No sub-module needed. The writeback register may reuse the existing preg-style pipeline register.

Test Plan:
- Reset then idle, is_invalid_in=1 → is_invalid_out=1, wb_we_out=0, dmem_req=0, stall_out=0.
- ALU op alu_in=0x0000_1234, rd_idx=5, reg_we=1 → next cycle wb_data=0x1234, wb_idx=5, fwd_valid=1, no stall.
- Load alu_in=0x100, ack 3 cycles after req with rdata=0xDEADBEEF → dmem_addr=0x40, stall_out high 4 cycles, then wb_data=0xDEADBEEF, wb_we=1.
- Store alu_in=0x204, store_data=0xCAFEF00D, ack next cycle → dmem_we=1, dmem_wdata=0xCAFEF00D, wb_we=0 (reg_we=0), stall 2 cycles.
- TIMEOUT=4, load with no ack → dmem_req drops after 4 BUSY cycles, mem_err_out=1 sticky, is_invalid_out=1; a later ack is ignored.
- rst asserted in 2nd BUSY cycle → next cycle dmem_req=0, stall_out=0, is_invalid_out=1, mem_err_out=0.
